onchip_mem_stream_reader: RTL and testbench

- Avalon-MM read master that sits directly in front of the on-chip memory slave (32-bit data, 14-bit word address, 10000 words, fixed 1-cycle read latency).
- Accepts a (base, length) command, reads consecutive words from the memory and emits them as an Avalon-ST packet with ready/valid backpressure.
- Uses an internal credit-controlled FIFO, so no read is ever issued whose data could not be stored.

---
 rtl/onchip_mem_stream_reader_if.sv | 36 +++
 rtl/onchip_mem_stream_reader.sv | 147 ++++++++++++++
 tb/tb_onchip_mem_stream_reader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_stream_reader_if.sv
// Command, on-chip memory read port and output stream of the memory stream reader.
// The master modport is the reader itself; slave is the surrounding system.
interface onchip_mem_stream_reader_if #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 15
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_sop;
    logic              out_eop;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, mem_readdata, out_ready,
        output cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_clken, out_valid, out_data, out_sop, out_eop
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, mem_readdata, out_ready,
        input  cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_clken, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Reads a (base, length) run of words from on-chip memory and streams them out as
// one packet; reads are only issued when the output FIFO has a free slot reserved.
//
//   state | meaning
//   IDLE  | waiting for a command (cmd_ready high)
//   RUN   | issuing reads, credit-limited by FIFO occupancy
//   DRAIN | all reads issued, waiting for the eop word to leave
module onchip_mem_stream_reader #(
    parameter int MEM_WORDS  = 10000,
    parameter int ADDR_W     = 14,
    parameter int LEN_W      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    onchip_mem_stream_reader_if.master bus,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len, len_last, issued, popped;
    logic              inflight;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              done_q, err_q;

    logic cmd_ready, accept, base_bad, credit_ok, issue, push, pop, last_pop, fifo_valid;

    assign base_bad   = 32'(bus.cmd_base) >= MEM_WORDS;
    assign len_last   = len - LEN_W'(1);
    assign credit_ok  = (fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);
    assign fifo_valid = fifo_count != '0;
    assign push       = inflight;
    assign pop        = fifo_valid && bus.out_ready;
    assign last_pop   = popped == len_last;
    assign accept     = bus.cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // cmd_ready is held low during the done cycle so a queued command waits one cycle.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !done_q && !reset;
                if (bus.cmd_valid && cmd_ready && !base_bad && bus.cmd_len != '0)
                    state_nxt = RUN;
            end
            RUN: begin
                issue = (issued < len) && credit_ok;
                if (issue && issued == len_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && last_pop)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            len        <= '0;
            issued     <= '0;
            popped     <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            inflight <= issue;

            if (accept) begin
                if (base_bad) begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end else if (bus.cmd_len == '0) begin
                    done_q <= 1'b1;
                end else begin
                    addr   <= bus.cmd_base;
                    len    <= bus.cmd_len;
                    issued <= '0;
                    popped <= '0;
                end
            end

            if (issue) begin
                addr   <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
                issued <= issued + LEN_W'(1);
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                popped <= popped + LEN_W'(1);
                if (last_pop) done_q <= 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_readdata;
    end

    assign bus.cmd_ready      = cmd_ready;
    assign bus.mem_address    = addr;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;

    // sop/eop derive from the pop counter, so they stay put while the head is stalled.
    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.out_sop   = fifo_valid && (popped == '0);
    assign bus.out_eop   = fifo_valid && last_pop;

    assign busy = state != IDLE;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader: expected addresses and stream words
// are queued at command accept and compared as the DUT issues reads and pops words.
module tb_onchip_mem_stream_reader;
    localparam int MEM_WORDS = 10000;
    localparam int ADDR_W    = 14;
    localparam int LEN_W     = 15;
    localparam int DEPTH     = 4;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, done, err;

    onchip_mem_stream_reader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

    onchip_mem_stream_reader #(
        .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.master), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory slave with one-cycle read latency
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rdata = 32'h0;
    initial for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
    always @(posedge clk) if (bus.mem_chipselect) rdata <= mem[bus.mem_address];
    assign bus.mem_readdata = rdata;

    int cyc = 0;
    always @(posedge clk) cyc++;

    word_t             sq[$];
    logic [ADDR_W-1:0] aq[$];

    int   cs_cnt = 0, ov_cnt = 0, pop_cnt = 0, done_cnt = 0;
    int   outstanding = 0, max_out = 0;
    int   done_cyc = 0, eop_cyc = 0, sop_cyc = 0;
    bit   eop_pending = 1'b0, last_err = 1'b0, prev_stall = 1'b0;
    logic [33:0] prev_head = '0;

    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
            sq.delete();
            aq.delete();
            prev_stall  = 1'b0;
            eop_pending = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 64'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data}),
                      64'({1'b1, prev_head}));
            if (bus.mem_chipselect) begin
                cs_cnt++;
                outstanding++;
                if (aq.size() == 0) check("addr_spurious", 64'(1), 64'(0));
                else check("mem_address", 64'(bus.mem_address), 64'(aq.pop_front()));
            end
            if (outstanding > max_out) max_out = outstanding;
            if (bus.out_valid) ov_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                outstanding--;
                if (sq.size() == 0) check("out_spurious", 64'(1), 64'(0));
                else check("out_word", 64'({bus.out_sop, bus.out_eop, bus.out_data}),
                           64'(sq.pop_front()));
                if (bus.out_sop) sop_cyc = cyc;
                if (bus.out_eop) begin
                    eop_cyc = cyc;
                    eop_pending = 1'b1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                last_err = err;
                if (eop_pending) check("done_after_eop", 64'(cyc - eop_cyc), 64'(1));
                eop_pending = 1'b0;
            end else if (err) begin
                check("err_without_done", 64'(1), 64'(0));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_head  = {bus.out_sop, bus.out_eop, bus.out_data};
        end
    end

    int acc_cyc = 0, done_base = 0;

    task automatic send_cmd(input int base, input int len);
        int k;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = ADDR_W'(base);
        bus.cmd_len   = LEN_W'(len);
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
        end
        if (k == 3000) begin
            check("cmd_accept_timeout", 64'(0), 64'(1));
        end else begin
            acc_cyc = cyc;
            if (base < MEM_WORDS)
                for (int i = 0; i < len; i++) begin
                    aq.push_back(ADDR_W'((base + i) % MEM_WORDS));
                    sq.push_back(word_t'({i == 0, i == len - 1,
                                          32'hA000_0000 + 32'((base + i) % MEM_WORDS)}));
                end
        end
        @(posedge clk);
        done_base = done_cnt;
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(posedge clk);
            if (done_cnt != done_base) break;
        end
        if (k == max_cyc) check("done_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [63:0] out_state();
        return 64'({bus.cmd_ready, bus.mem_chipselect, bus.mem_address, bus.out_valid,
                    bus.out_sop, bus.out_eop, busy, done, err});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cs0, ov0, p0, d0, k;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_state(), 64'(0));
        check("mem_constants", 64'({bus.mem_write, bus.mem_byteenable, bus.mem_clken}),
              64'({1'b0, 4'hF, 1'b1}));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.cmd_ready), 64'(1));

        // basic read with latency checks
        send_cmd(5, 4);
        @(negedge clk);
        check("issue_latency", 64'(bus.mem_chipselect), 64'(1));
        check("busy_in_run", 64'(busy), 64'(1));
        check("valid_cycle1", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("valid_cycle2", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("valid_cycle3", 64'(bus.out_valid), 64'(1));
        wait_done(50);
        check("basic_err", 64'(last_err), 64'(0));
        check("basic_consecutive", 64'(eop_cyc - sop_cyc), 64'(3));

        // address wrap
        send_cmd(9998, 4);
        wait_done(50);
        check("wrap_err", 64'(last_err), 64'(0));

        // backpressure
        max_out = 0;
        send_cmd(1000, 16);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 bus.out_ready = ~bus.out_ready;
        end
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_done(200);
        check("credit_max", 64'(max_out), 64'(DEPTH));

        // zero length
        cs0 = cs_cnt; ov0 = ov_cnt;
        send_cmd(50, 0);
        wait_done(20);
        check("len0_err", 64'(last_err), 64'(0));
        check("len0_no_reads", 64'(cs_cnt - cs0), 64'(0));
        check("len0_no_output", 64'(ov_cnt - ov0), 64'(0));

        // out-of-range base
        cs0 = cs_cnt;
        send_cmd(10000, 5);
        wait_done(20);
        check("badbase_err", 64'(last_err), 64'(1));
        check("badbase_no_reads", 64'(cs_cnt - cs0), 64'(0));

        // single word
        send_cmd(77, 1);
        wait_done(20);
        check("len1_same_word", 64'(eop_cyc - sop_cyc), 64'(0));

        // reset in the middle of a long command
        p0 = pop_cnt;
        send_cmd(300, 100);
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            if (pop_cnt - p0 >= 20) break;
        end
        if (k == 300) check("reset_wait_timeout", 64'(0), 64'(1));
        #1 reset = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        @(negedge clk);
        check("midrun_reset_outputs", out_state(), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_midrun_reset", 64'(bus.cmd_ready), 64'(1));
        repeat (5) @(posedge clk);
        check("no_done_after_reset", 64'(done_cnt), 64'(d0));
        send_cmd(0, 2);
        wait_done(50);
        check("post_reset_err", 64'(last_err), 64'(0));

        // back-to-back: second command held valid while the first runs
        send_cmd(400, 6);
        send_cmd(500, 3);
        check("b2b_accept_gap", 64'(acc_cyc - done_cyc), 64'(1));
        wait_done(50);

        repeat (5) @(posedge clk);
        check("stream_queue_empty", 64'(sq.size()), 64'(0));
        check("addr_queue_empty", 64'(aq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
